// File: rtl/a2d_sequencer.sv
// a2d_sequencer: round-robin ADC128S sequencer (ch0/ch4/ch5) driving an SPI master via wrt/cmd/done/rd_data, results on lft_ld/rght_ld/batt with vld pulses
module a2d_sequencer #(
  parameter logic [19:0] PERIOD = 20'd1_000_000,
  parameter int GAP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nxt,
  input  logic        auto_en,
  output logic        wrt,
  output logic [15:0] cmd,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] batt,
  output logic        lft_vld,
  output logic        rght_vld,
  output logic        batt_vld,
  output logic        busy,
  output logic [1:0]  ch_ptr
);
  localparam int GW = $clog2(GAP + 1);
  typedef enum logic [1:0] {IDLE, CMD, GAP_W, READ} state_t;
  state_t state, state_n;
  logic [19:0] timer;
  logic [GW-1:0] gap_cnt;
  logic pending, trig, start, cap;
  logic [2:0] chan;
  logic unused_bits;
  assign unused_bits = ^rd_data[15:12];
  assign trig = nxt | (auto_en & (timer == PERIOD - 20'd1));
  assign chan = ch_ptr == 2'd0 ? 3'b000 : ch_ptr == 2'd1 ? 3'b100 : 3'b101;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    start = 1'b0;
    cap = 1'b0;
    case (state)
      IDLE: if (trig | pending) begin
        state_n = CMD;
        start = 1'b1;
      end
      CMD: if (done) state_n = GAP_W;
      GAP_W: if (gap_cnt == '0) state_n = READ;
      READ: if (done) begin
        state_n = IDLE;
        cap = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      timer <= '0;
      gap_cnt <= '0;
      pending <= 1'b0;
      wrt <= 1'b0;
      cmd <= '0;
      lft_ld <= '0;
      rght_ld <= '0;
      batt <= '0;
      lft_vld <= 1'b0;
      rght_vld <= 1'b0;
      batt_vld <= 1'b0;
      ch_ptr <= '0;
    end else begin
      timer <= (!auto_en || timer == PERIOD - 20'd1) ? '0 : timer + 20'd1;
      // reloaded every CMD cycle so it holds GAP-1 on entry to GAP_W
      gap_cnt <= state == CMD ? GW'(GAP - 1) : gap_cnt - GW'(state == GAP_W);
      // one-deep queue: only a busy trigger is remembered, IDLE consumes it
      pending <= busy & (pending | trig);
      wrt <= start | (state == GAP_W && gap_cnt == '0);
      if (start) cmd <= {2'b00, chan, 11'h000};
      lft_vld <= cap & (ch_ptr == 2'd0);
      rght_vld <= cap & (ch_ptr == 2'd1);
      batt_vld <= cap & (ch_ptr == 2'd2);
      if (cap && ch_ptr == 2'd0) lft_ld <= rd_data[11:0];
      if (cap && ch_ptr == 2'd1) rght_ld <= rd_data[11:0];
      if (cap && ch_ptr == 2'd2) batt <= rd_data[11:0];
      if (cap) ch_ptr <= ch_ptr == 2'd2 ? 2'd0 : ch_ptr + 2'd1;
    end
endmodule
